// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for both clock domains of the asynchronous FIFO.
//
//   Contents:
//     DEF_ADDRSIZE  default number of memory address bits
//     DEPTH         number of memory words at the default address size
//     bin2gray()    binary to reflected Gray conversion
//     gray2bin()    reflected Gray to binary conversion
//
//   Both conversion functions take a zero-extended 32-bit operand. Bits above
//   the real pointer width are zero, so they contribute nothing to either
//   conversion. One function therefore serves every pointer width up to 32
//   bits. Callers slice the result back down to their own width.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_ADDRSIZE = 4;
  localparam int DEPTH        = 2 ** DEF_ADDRSIZE;

  // Widest pointer the conversion helpers accept.
  localparam int PTR_MAXW     = 32;

  // Each Gray bit is the XOR of two adjacent binary bits.
  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] gray);
    logic [PTR_MAXW-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_MAXW; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_r2w.sv
// -----------------------------------------------------------------------------
// sync_r2w
//   Two-flop synchronizer. It carries the read-domain Gray pointer into the
//   write clock domain. The read side uses the same structure, mirrored, as
//   sync_w2r.
//
//   The pointer is Gray coded, so at most one bit changes per read-side
//   update. A sample taken during that change therefore resolves to either
//   the old pointer or the new one. Either value is safe for the full and
//   level logic downstream.
//
//   Ports:
//     wclk      in   write-domain clock
//     wrst_n    in   synchronous active-low reset
//     rptr      in   WIDTH  read-domain Gray pointer (asynchronous)
//     wq2_rptr  out  WIDTH  second synchronizer stage
// -----------------------------------------------------------------------------
module sync_r2w
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_ADDRSIZE + 1
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-1:0] wq2_rptr
);

  // First stage; it may go metastable and is read only by the second stage.
  logic [WIDTH-1:0] wq1_rptr;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule : sync_r2w

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
//   Write-domain control for the asynchronous FIFO. It keeps the binary and
//   Gray write pointers and accepts writes when winc is high. It also brings
//   the read pointer across the clock boundary and produces registered
//   full, almost-full and fill-level status.
//
//   Parameters:
//     ADDRSIZE      memory address bits (>= 2); DEPTH = 2**ADDRSIZE
//     AFULL_MARGIN  walmost_full is set when the level is at least
//                   DEPTH - AFULL_MARGIN (1..DEPTH-1)
//
//   Ports:
//     wclk          in   write clock
//     wrst_n        in   synchronous active-low reset
//     winc          in   write request; ignored while wfull is set
//     rptr          in   ADDRSIZE+1  read-domain Gray pointer (asynchronous)
//     waddr         out  ADDRSIZE    memory write address
//     wptr          out  ADDRSIZE+1  registered Gray write pointer
//     wfull         out  registered full flag
//     walmost_full  out  registered almost-full flag
//     wlevel        out  ADDRSIZE+1  registered fill level, 0..DEPTH
//
//   The flags and the level all use the read pointer after synchronization.
//   That view is two cycles old, so space freed by the reader appears late.
//   The FIFO therefore never reports more free space than really exists.
// -----------------------------------------------------------------------------
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = DEF_ADDRSIZE,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel
);

  localparam int PW         = ADDRSIZE + 1;
  localparam int FIFO_DEPTH = 2 ** ADDRSIZE;

  localparam logic [PW-1:0] AFULL_LEVEL = PW'(FIFO_DEPTH - AFULL_MARGIN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wbin;
  logic [PW-1:0] wq2_rptr;

  // ---------------------------------------------------------------------------
  // Next-state evaluation
  // ---------------------------------------------------------------------------
  logic                winc_ok;
  logic [PW-1:0]       wbinnext;
  logic [PW-1:0]       wgraynext;
  logic [PW-1:0]       rq2_bin;
  logic [PW-1:0]       wlevel_next;
  logic [PW-1:0]       full_match;
  logic [PTR_MAXW-1:0] wgray_wide;
  logic [PTR_MAXW-1:0] rbin_wide;

  // A write that arrives while the FIFO is full is dropped, and the
  // pointers do not move.
  assign winc_ok  = winc & ~wfull;

  // Adding one wraps naturally at 2**PW. The extra pointer bit keeps full
  // and empty distinct across the wrap.
  assign wbinnext = wbin + PW'(winc_ok);

  assign wgray_wide = bin2gray({{(PTR_MAXW-PW){1'b0}}, wbinnext});
  assign wgraynext  = wgray_wide[PW-1:0];

  // Decode only the second synchronizer stage. The first stage may still be
  // settling.
  assign rbin_wide = gray2bin({{(PTR_MAXW-PW){1'b0}}, wq2_rptr});
  assign rq2_bin   = rbin_wide[PW-1:0];

  // The difference is taken modulo 2**PW, so a wrapped write pointer still
  // gives the true occupancy. Since the writer never gets more than DEPTH
  // ahead of the reader, the result stays in the range 0..DEPTH.
  assign wlevel_next = wbinnext - rq2_bin;

  // In Gray code, "writer is exactly one lap ahead" means the two MSBs are
  // inverted and all lower bits are equal.
  assign full_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // ---------------------------------------------------------------------------
  // Read-pointer synchronizer
  // ---------------------------------------------------------------------------
  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  // ---------------------------------------------------------------------------
  // Pointer and status registers
  // ---------------------------------------------------------------------------
  // The flags use the same next-state values as the pointer. wfull is
  // therefore set on the same edge that accepts the last free slot.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= (wgraynext == full_match);
      walmost_full <= (wlevel_next >= AFULL_LEVEL);
      wlevel       <= wlevel_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

endmodule : wptr_full_ctrl

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
//   Directed, self-checking bench for wptr_full_ctrl with ADDRSIZE = 4 and
//   AFULL_MARGIN = 2. Inputs change 1 ns after a rising edge, and outputs are
//   sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;

  int total = 0;
  int bad   = 0;

  wptr_full_ctrl #(
    .ADDRSIZE     (4),
    .AFULL_MARGIN (2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr         (rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset;
    wrst_n = 1'b0; winc = 1'b1; rptr = 5'b10110;
    for (int c = 0; c < 3; c++) begin
      tick();
      total += 5;
      if (waddr !== 4'd0)        begin bad++; $display("FAIL reset_waddr cyc=%0d got=%0d exp=0", c, waddr); end
      if (wptr !== 5'd0)         begin bad++; $display("FAIL reset_wptr cyc=%0d got=%b exp=00000", c, wptr); end
      if (wfull !== 1'b0)        begin bad++; $display("FAIL reset_wfull cyc=%0d got=%b exp=0", c, wfull); end
      if (walmost_full !== 1'b0) begin bad++; $display("FAIL reset_afull cyc=%0d got=%b exp=0", c, walmost_full); end
      if (wlevel !== 5'd0)       begin bad++; $display("FAIL reset_wlevel cyc=%0d got=%0d exp=0", c, wlevel); end
    end
    wrst_n = 1'b1;
    tick();
    total += 2;
    if (waddr !== 4'd1)    begin bad++; $display("FAIL reset_first_waddr got=%0d exp=1", waddr); end
    if (wptr !== 5'b00001) begin bad++; $display("FAIL reset_first_wptr got=%b exp=00001", wptr); end
    // Return to a clean, empty state with rptr at zero.
    winc = 1'b0; rptr = 5'd0; wrst_n = 1'b0;
    tick(); tick();
    wrst_n = 1'b1;
  endtask

  task automatic test_fill;
    winc = 1'b1; rptr = 5'd0;
    for (int k = 1; k <= 16; k++) begin
      total += 1;
      if (waddr !== 4'(k-1)) begin bad++; $display("FAIL fill_waddr k=%0d got=%0d exp=%0d", k, waddr, k-1); end
      tick();
      total += 3;
      if (wlevel !== 5'(k))               begin bad++; $display("FAIL fill_wlevel k=%0d got=%0d exp=%0d", k, wlevel, k); end
      if (wfull !== (k == 16))            begin bad++; $display("FAIL fill_wfull k=%0d got=%b exp=%b", k, wfull, k == 16); end
      if (walmost_full !== (k >= 14))     begin bad++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, walmost_full, k >= 14); end
    end
    total += 1;
    if (wptr !== 5'b11000) begin bad++; $display("FAIL fill_wptr got=%b exp=11000", wptr); end
    // A 17th write request must be ignored.
    tick();
    total += 4;
    if (wptr !== 5'b11000) begin bad++; $display("FAIL overflow_wptr got=%b exp=11000", wptr); end
    if (waddr !== 4'd0)    begin bad++; $display("FAIL overflow_waddr got=%0d exp=0", waddr); end
    if (wlevel !== 5'd16)  begin bad++; $display("FAIL overflow_wlevel got=%0d exp=16", wlevel); end
    if (wfull !== 1'b1)    begin bad++; $display("FAIL overflow_wfull got=%b exp=1", wfull); end
    winc = 1'b0;
  endtask

  task automatic test_drain_one;
    rptr = 5'b00001;
    tick();
    total += 1;
    if (wfull !== 1'b1) begin bad++; $display("FAIL drain_wfull_e1 got=%b exp=1", wfull); end
    tick();
    total += 1;
    if (wfull !== 1'b1) begin bad++; $display("FAIL drain_wfull_e2 got=%b exp=1", wfull); end
    tick();
    total += 3;
    if (wfull !== 1'b0)        begin bad++; $display("FAIL drain_wfull_e3 got=%b exp=0", wfull); end
    if (wlevel !== 5'd15)      begin bad++; $display("FAIL drain_wlevel got=%0d exp=15", wlevel); end
    if (walmost_full !== 1'b1) begin bad++; $display("FAIL drain_afull got=%b exp=1", walmost_full); end
  endtask

  task automatic test_simultaneous;
    // wbin = 16; read pointer moves to 6, so the level settles at 10.
    rptr = g(5'd6);
    repeat (3) tick();
    total += 2;
    if (wlevel !== 5'd10)      begin bad++; $display("FAIL simul_pre_wlevel got=%0d exp=10", wlevel); end
    if (walmost_full !== 1'b0) begin bad++; $display("FAIL simul_pre_afull got=%b exp=0", walmost_full); end
    winc = 1'b1; rptr = g(5'd7);
    tick();
    winc = 1'b0;
    total += 1;
    if (wlevel !== 5'd11) begin bad++; $display("FAIL simul_e1_wlevel got=%0d exp=11", wlevel); end
    tick();
    total += 1;
    if (wlevel !== 5'd11) begin bad++; $display("FAIL simul_e2_wlevel got=%0d exp=11", wlevel); end
    tick();
    total += 2;
    if (wlevel !== 5'd10) begin bad++; $display("FAIL simul_e3_wlevel got=%0d exp=10", wlevel); end
    if (wfull !== 1'b0)   begin bad++; $display("FAIL simul_e3_wfull got=%b exp=0", wfull); end
  endtask

  task automatic test_midreset;
    // wbin = 17; read pointer at 5, so the level is 12.
    rptr = g(5'd5);
    repeat (3) tick();
    total += 1;
    if (wlevel !== 5'd12) begin bad++; $display("FAIL midrst_pre_wlevel got=%0d exp=12", wlevel); end
    wrst_n = 1'b0; winc = 1'b1; rptr = 5'd0;
    tick();
    total += 5;
    if (waddr !== 4'd0)        begin bad++; $display("FAIL midrst_waddr got=%0d exp=0", waddr); end
    if (wptr !== 5'd0)         begin bad++; $display("FAIL midrst_wptr got=%b exp=00000", wptr); end
    if (wfull !== 1'b0)        begin bad++; $display("FAIL midrst_wfull got=%b exp=0", wfull); end
    if (walmost_full !== 1'b0) begin bad++; $display("FAIL midrst_afull got=%b exp=0", walmost_full); end
    if (wlevel !== 5'd0)       begin bad++; $display("FAIL midrst_wlevel got=%0d exp=0", wlevel); end
    wrst_n = 1'b1;
    tick();
    winc = 1'b0;
    total += 3;
    if (waddr !== 4'd1)    begin bad++; $display("FAIL midrst_after_waddr got=%0d exp=1", waddr); end
    if (wptr !== 5'b00001) begin bad++; $display("FAIL midrst_after_wptr got=%b exp=00001", wptr); end
    if (wlevel !== 5'd1)   begin bad++; $display("FAIL midrst_after_wlevel got=%0d exp=1", wlevel); end
  endtask

  task automatic test_wrap;
    logic [4:0] wb;
    logic [4:0] prev;
    wrst_n = 1'b0; winc = 1'b0; rptr = 5'd0;
    tick();
    wrst_n = 1'b1;
    wb   = 5'd0;
    prev = 5'd0;
    // rptr echoes the write pointer. The two sync stages plus the level
    // register then hold the level at 3 once the pipeline has filled.
    for (int k = 1; k <= 40; k++) begin
      winc = 1'b1;
      rptr = g(wb);
      tick();
      wb = wb + 5'd1;
      total += 4;
      if (waddr !== wb[3:0])          begin bad++; $display("FAIL wrap_waddr k=%0d got=%0d exp=%0d", k, waddr, wb[3:0]); end
      if (wptr !== g(wb))             begin bad++; $display("FAIL wrap_wptr k=%0d got=%b exp=%b", k, wptr, g(wb)); end
      if ($countones(wptr ^ prev) > 1) begin bad++; $display("FAIL wrap_gray_step k=%0d got=%b prev=%b exp<=1bit", k, wptr, prev); end
      if (wfull !== 1'b0)             begin bad++; $display("FAIL wrap_wfull k=%0d got=%b exp=0", k, wfull); end
      if (k >= 3) begin
        total += 1;
        if (wlevel !== 5'd3) begin bad++; $display("FAIL wrap_wlevel k=%0d got=%0d exp=3", k, wlevel); end
      end
      prev = wptr;
    end
    winc = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b0;
    winc   = 1'b0;
    rptr   = 5'd0;
    #1;
    test_reset();
    test_fill();
    test_drain_one();
    test_simultaneous();
    test_midreset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wptr_full_ctrl
